// File: rtl/mmio_ctrl.sv
// rtl/mmio_ctrl.sv - memory-mapped I/O block for the 0xFFxx window: LEDs, HEX, debounced keys/switches, interval timer, irq
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   addr, wdata         byte address and store data from the M stage
//   we, re              store strobe, load strobe (re only drives read side effects)
//   sel, rdata          combinational address hit and read data
//   keys_in, sw_in      raw key pads (active-low) and switches
//   hex_out, ledr_out,
//   ledg_out            output registers
//   irq                 registered interrupt request
module mmio_ctrl #(
    parameter int DBITS    = 16,
    parameter int NKEYS    = 4,
    parameter int NSW      = 10,
    parameter int NLEDR    = 10,
    parameter int NLEDG    = 8,
    parameter int PRESCALE = 50000,
    parameter int DEBOUNCE = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wdata,
    input  logic             we,
    input  logic             re,
    output logic             sel,
    output logic [DBITS-1:0] rdata,
    input  logic [NKEYS-1:0] keys_in,
    input  logic [NSW-1:0]   sw_in,
    output logic [15:0]      hex_out,
    output logic [NLEDR-1:0] ledr_out,
    output logic [NLEDG-1:0] ledg_out,
    output logic             irq
);

    localparam logic [DBITS-1:0] A_KDATA = DBITS'(16'hFFF0);
    localparam logic [DBITS-1:0] A_SDATA = DBITS'(16'hFFF2);
    localparam logic [DBITS-1:0] A_KCTRL = DBITS'(16'hFFF4);
    localparam logic [DBITS-1:0] A_HEX   = DBITS'(16'hFFF8);
    localparam logic [DBITS-1:0] A_LEDR  = DBITS'(16'hFFFA);
    localparam logic [DBITS-1:0] A_LEDG  = DBITS'(16'hFFFC);
    localparam logic [DBITS-1:0] A_TCNT  = DBITS'(16'hFFE0);
    localparam logic [DBITS-1:0] A_TLIM  = DBITS'(16'hFFE4);
    localparam logic [DBITS-1:0] A_TCTL  = DBITS'(16'hFFE8);

    localparam int PW = $clog2(PRESCALE);
    localparam int CW = $clog2(DEBOUNCE + 1);

    // Control registers are held as {ie, o, r}.
    logic [2:0]       kctl, tctl;
    logic [2:0]       kctl_next, tctl_next;
    logic [DBITS-1:0] tcnt, tlim;
    logic [PW-1:0]    pre;
    logic             tick, tmatch;

    logic [NKEYS-1:0] key_s1, key_s2, key_last, kdata;
    logic [CW-1:0]    key_cnt;
    logic             key_stable, key_upd;
    logic [NSW-1:0]   sw_s1, sw_s2, sw_last, sdata;
    logic [CW-1:0]    sw_cnt;
    logic             sw_stable, sw_upd;

    logic wr_kctl, wr_tctl, wr_tcnt, rd_kdata;

    assign wr_kctl  = we && (addr == A_KCTRL);
    assign wr_tctl  = we && (addr == A_TCTL);
    assign wr_tcnt  = we && (addr == A_TCNT);
    assign rd_kdata = re && (addr == A_KDATA);

    assign tick   = (pre == PW'(PRESCALE - 1));
    // A TCNT store overrides the tick, so it also suppresses the limit match.
    assign tmatch = tick && !wr_tcnt && (tlim != '0) && (tcnt == tlim - DBITS'(1));

    // A vector is stable when the synchronised value matches last cycle's;
    // requiring this for the update keeps a saturated counter from accepting
    // a brand-new value before it has been restarted.
    assign key_stable = (key_s2 == key_last);
    assign key_upd    = key_stable && (key_cnt == CW'(DEBOUNCE)) && (key_s2 != kdata);
    assign sw_stable  = (sw_s2 == sw_last);
    assign sw_upd     = sw_stable && (sw_cnt == CW'(DEBOUNCE)) && (sw_s2 != sdata);

    // Ready/overrun update: set beats write-clear; a read landing on the same
    // edge as a set leaves R at 1 without raising overrun.
    function automatic logic [2:0] ctrl_next(input logic [2:0] cur, input logic set,
                                             input logic rd_clr, input logic wr,
                                             input logic [2:0] wbits);
        logic r, o, ie;
        r  = cur[0];
        o  = cur[1];
        ie = cur[2];
        if (wr) begin
            ie = wbits[2];
            if (!wbits[0]) r = 1'b0;
            if (!wbits[1]) o = 1'b0;
        end
        if (rd_clr) r = 1'b0;
        if (set) begin
            if (cur[0] && !rd_clr) o = 1'b1;
            r = 1'b1;
        end
        return {ie, o, r};
    endfunction

    assign kctl_next = ctrl_next(kctl, key_upd, rd_kdata, wr_kctl, {wdata[4], wdata[1:0]});
    assign tctl_next = ctrl_next(tctl, tmatch, 1'b0, wr_tctl, {wdata[4], wdata[1:0]});

    always_comb begin
        sel   = 1'b1;
        rdata = '0;
        case (addr)
            A_KDATA: rdata = DBITS'(kdata);
            A_SDATA: rdata = DBITS'(sdata);
            A_KCTRL: rdata = DBITS'({kctl[2], 2'b00, kctl[1], kctl[0]});
            A_HEX:   rdata = DBITS'(hex_out);
            A_LEDR:  rdata = DBITS'(ledr_out);
            A_LEDG:  rdata = DBITS'(ledg_out);
            A_TCNT:  rdata = tcnt;
            A_TLIM:  rdata = tlim;
            A_TCTL:  rdata = DBITS'({tctl[2], 2'b00, tctl[1], tctl[0]});
            default: begin
                sel   = 1'b0;
                rdata = DBITS'(16'hDEAD);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1   <= '1;
            key_s2   <= '1;
            key_last <= '1;
            kdata    <= '1;
            key_cnt  <= '0;
            sw_s1    <= '0;
            sw_s2    <= '0;
            sw_last  <= '0;
            sdata    <= '0;
            sw_cnt   <= '0;
        end else begin
            key_s1   <= keys_in;
            key_s2   <= key_s1;
            key_last <= key_s2;
            if (!key_stable)
                key_cnt <= '0;
            else if (tick && key_cnt != CW'(DEBOUNCE))
                key_cnt <= key_cnt + CW'(1);
            if (key_upd)
                kdata <= key_s2;

            sw_s1   <= sw_in;
            sw_s2   <= sw_s1;
            sw_last <= sw_s2;
            if (!sw_stable)
                sw_cnt <= '0;
            else if (tick && sw_cnt != CW'(DEBOUNCE))
                sw_cnt <= sw_cnt + CW'(1);
            if (sw_upd)
                sdata <= sw_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_out  <= '0;
            ledr_out <= '0;
            ledg_out <= '0;
            tcnt     <= '0;
            tlim     <= '0;
            pre      <= '0;
            kctl     <= '0;
            tctl     <= '0;
            irq      <= 1'b0;
        end else begin
            if (we && addr == A_HEX)  hex_out  <= wdata[15:0];
            if (we && addr == A_LEDR) ledr_out <= wdata[NLEDR-1:0];
            if (we && addr == A_LEDG) ledg_out <= wdata[NLEDG-1:0];
            if (we && addr == A_TLIM) tlim     <= wdata;

            if (wr_tcnt) begin
                tcnt <= wdata;
                pre  <= '0;
            end else begin
                pre <= tick ? '0 : pre + PW'(1);
                if (tmatch)
                    tcnt <= '0;
                else if (tick)
                    tcnt <= tcnt + DBITS'(1);
            end

            kctl <= kctl_next;
            tctl <= tctl_next;
            irq  <= (kctl[0] & kctl[2]) | (tctl[0] & tctl[2]);
        end
    end

endmodule
